net_sequencer: RTL

Controller that runs a multi-layer inference on one shared, time-multiplexed layer engine (matmul → bias add → sigmoid). It accepts an inference request with a valid/ready handshake and walks the layer index through 0..L-1. For each layer it resets the engine, pulses its start, waits for done with a timeout, then swaps the ping-pong activation buffer. It returns a result handshake with a latency count, and sits between the host/testbench and the layer datapath plus its weight/bias bank mux.

---
 rtl/net_sequencer_if.sv | 21 ++
 rtl/net_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/net_sequencer_if.sv
// Host-side request/result handshake of the inference sequencer.
interface net_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err_timeout;
    logic [31:0] lat;

    modport master (
        output in_valid, abort, out_ready,
        input  in_ready, out_valid, busy, err_timeout, lat
    );

    modport slave (
        input  in_valid, abort, out_ready,
        output in_ready, out_valid, busy, err_timeout, lat
    );
endinterface

// File: rtl/net_sequencer.sv
// Multi-layer inference sequencer driving one shared layer engine.
module net_sequencer #(
    parameter int L       = 2,
    parameter int LW      = 2,
    parameter int TW      = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst,
    net_sequencer_if.slave host,
    output logic           eng_rst_n,
    output logic           eng_start,
    input  logic           eng_done,
    output logic [LW-1:0]  layer_sel,
    output logic           buf_swap
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_START, S_WAIT, S_NEXT, S_OUT, S_ABRT
    } state_t;

    localparam logic [LW-1:0] LAST = LW'(L - 1);
    localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
    localparam logic [TW-1:0] ONE  = TW'(1);

    state_t        state_q, state_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic [31:0]   lat_q, lat_d;
    logic          err_q, err_d;
    logic          run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            wcnt_q  <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            wcnt_q  <= wcnt_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    assign run = (state_q == S_CLR) || (state_q == S_START) ||
                 (state_q == S_WAIT) || (state_q == S_NEXT);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        wcnt_d  = wcnt_q;
        lat_d   = lat_q;
        err_d   = err_q;
        if (run && lat_q != '1)
            lat_d = lat_q + 32'd1;
        unique case (state_q)
            S_IDLE: begin
                if (host.in_valid) begin
                    state_d = S_CLR;
                    layer_d = '0;
                    lat_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_CLR:   state_d = host.abort ? S_ABRT : S_START;
            S_START: begin
                if (host.abort) begin
                    state_d = S_ABRT;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = ONE;
                end
            end
            // first WAIT cycle ignores done left over from the prior layer
            S_WAIT: begin
                if (host.abort) begin
                    state_d = S_ABRT;
                end else if (eng_done && wcnt_q != ONE) begin
                    state_d = S_NEXT;
                end else if (wcnt_q == TMO) begin
                    state_d = S_ABRT;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + ONE;
                end
            end
            S_NEXT: begin
                if (host.abort) begin
                    state_d = S_ABRT;
                end else if (layer_q == LAST) begin
                    state_d = S_OUT;
                end else begin
                    layer_d = layer_q + LW'(1);
                    state_d = S_CLR;
                end
            end
            S_OUT: begin
                if (host.out_ready)
                    state_d = S_IDLE;
            end
            S_ABRT: begin
                state_d = S_IDLE;
                layer_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // reset forces every output to its idle-off value within the rst cycle
    assign host.in_ready    = !rst && state_q == S_IDLE;
    assign host.out_valid   = !rst && state_q == S_OUT;
    assign host.busy        = !rst && state_q != S_IDLE;
    assign host.err_timeout = !rst && err_q;
    assign host.lat         = rst ? '0 : lat_q;
    assign eng_rst_n = !rst && state_q != S_CLR && state_q != S_ABRT;
    assign eng_start = !rst && state_q == S_START;
    assign buf_swap  = !rst && state_q == S_NEXT;
    assign layer_sel = rst ? '0 : layer_q;
endmodule
